btn_mode_ctrl: RTL and testbench

//  Upstream stage of bin_counter. Turns a raw, bouncing push-button into a clean

---
 rtl/btn_mode_ctrl.sv | 113 +++++++++++
 tb/tb_btn_mode_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/btn_mode_ctrl.sv
// rtl/btn_mode_ctrl.sv - synchronised, debounced push-button with press/release strobes and toggling mode level
module btn_mode_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit MODE_INIT       = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_btn_db,
  output logic o_press,
  output logic o_release,
  output logic o_mode
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PWAIT,
    HELD,
    RWAIT
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            btn_db_d, press_d, release_d, mode_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_btn};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      o_btn_db  <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_mode    <= MODE_INIT;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      o_btn_db  <= btn_db_d;
      o_press   <= press_d;
      o_release <= release_d;
      o_mode    <= mode_d;
    end
  end

  // Strobes default low so each is asserted for exactly the accepting edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    btn_db_d  = o_btn_db;
    press_d   = 1'b0;
    release_d = 1'b0;
    mode_d    = o_mode;

    unique case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = PWAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PWAIT: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = HELD;
          press_d  = 1'b1;
          btn_db_d = 1'b1;
          mode_d   = ~o_mode;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync) begin
          state_d = RWAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RWAIT: begin
        if (sync) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          btn_db_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// tb/tb_btn_mode_ctrl.sv - randomized and directed checks of btn_mode_ctrl against a run-length debounce model
module tb_btn_mode_ctrl;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam bit MODE_INIT       = 1'b0;
  localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic btn_db, press, release_s, mode;

  int errors = 0;
  int checks = 0;

  btn_mode_ctrl #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .MODE_INIT      (MODE_INIT)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_btn    (btn),
    .o_btn_db (btn_db),
    .o_press  (press),
    .o_release(release_s),
    .o_mode   (mode)
  );

  always #5 clk = ~clk;

  // Model: the debouncer sees the input delayed by SYNC_STAGES edges and
  // accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
  logic hist[$];
  int   run;
  logic m_db, m_press, m_rel, m_mode;
  int   edge_n;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_edge(input logic b, input logic r);
    logic s;
    if (r) begin
      hist.delete();
      for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(1'b0);
      run = 0; m_db = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_mode = MODE_INIT;
      edge_n = 0;
    end else begin
      s = hist.pop_front();
      hist.push_back(b);
      m_press = 1'b0;
      m_rel   = 1'b0;
      edge_n++;
      if (s != m_db) begin
        run++;
        if (run == DEBOUNCE_CYCLES) begin
          m_db    = s;
          run     = 0;
          m_press = s;
          m_rel   = ~s;
          if (s) m_mode = ~m_mode;
        end
      end else begin
        run = 0;
      end
    end
  endtask

  task automatic step(input logic b, input logic r);
    @(negedge clk);
    btn = b;
    rst = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    check_val("btn_db", btn_db, m_db);
    check_val("press", press, m_press);
    check_val("release", release_s, m_rel);
    check_val("mode", mode, m_mode);
  endtask

  // Hold btn for n edges; report first edge (counted from reset) of each strobe.
  task automatic hold(input logic b, input int n, output int press_at, output int rel_at);
    press_at = -1;
    rel_at   = -1;
    for (int i = 0; i < n; i++) begin
      step(b, 1'b0);
      if (press === 1'b1 && press_at < 0) press_at = edge_n;
      if (release_s === 1'b1 && rel_at < 0) rel_at = edge_n;
    end
  endtask

  initial begin
    int pa, ra, base;
    logic v;
    int len;

    // Reset held two cycles
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_val("reset_db", btn_db, 1'b0);
    check_val("reset_press", press, 1'b0);
    check_val("reset_release", release_s, 1'b0);
    check_val("reset_mode", mode, MODE_INIT);

    // Clean press: first strobe on edge LAT
    hold(1'b1, 10, pa, ra);
    check_val("press_latency", pa, LAT);
    check_val("press_db", btn_db, 1'b1);
    check_val("press_mode", mode, 1'b1);

    // Release from HELD, same latency counted from first 0 sample
    base = edge_n;
    hold(1'b0, 10, pa, ra);
    check_val("release_latency", ra - base, LAT);
    check_val("release_no_press", pa, -1);
    check_val("release_db", btn_db, 1'b0);
    check_val("release_mode", mode, 1'b1);

    // Bounce shorter than the debounce window
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    hold(1'b0, 10, pa, ra);
    check_val("bounce_no_press", pa, -1);
    check_val("bounce_mode", mode, 1'b1);

    // Glitch of DEBOUNCE_CYCLES-1 samples
    hold(1'b1, DEBOUNCE_CYCLES - 1, pa, ra);
    hold(1'b0, 10, pa, ra);
    check_val("glitch_db", btn_db, 1'b0);

    // Second full press/release returns mode to 0
    hold(1'b1, 10, pa, ra);
    check_val("second_press_mode", mode, 1'b0);
    hold(1'b0, 10, pa, ra);
    check_val("second_release_mode", mode, 1'b0);

    // Reset on edge 4 of a press, button held through it
    step(1'b0, 1'b1);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check_val("abort_press", press, 1'b0);
    check_val("abort_mode", mode, MODE_INIT);
    hold(1'b1, 10, pa, ra);
    check_val("after_reset_latency", pa, LAT);

    // Random runs with occasional reset
    for (int k = 0; k < 600; k++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * DEBOUNCE_CYCLES);
      for (int j = 0; j < len; j++) begin
        step(v, ($urandom_range(0, 299) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
